dmem_arbiter: RTL and testbench

- Two-port arbiter that shares the single-port data memory (32-bit words, 1025 entries, synchronous read, write on clock edge) between the processor datapath and the host debug/loader port.
- Grants one access per cycle using round-robin priority, with a host lock for atomic read-modify-write sequences.
- Returns read data one cycle after grant, with a per-requester valid strobe.
- Suppresses and flags out-of-range accesses.

---
 rtl/dmem_arbiter.sv | 122 ++++++++++++
 tb/tb_dmem_arbiter.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between the CPU and the host port.
// The host can lock the memory across accesses for read-modify-write sequences.
module dmem_arbiter #(
  parameter int unsigned DW    = 32,
  parameter int unsigned AW    = 32,
  parameter int unsigned DEPTH = 1025
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          c_req,
  input  logic          c_wr,
  input  logic [AW-1:0] c_adr,
  input  logic [DW-1:0] c_wd,
  output logic          c_gnt,
  output logic          c_rvalid,
  output logic [DW-1:0] c_rd,
  input  logic          h_req,
  input  logic          h_wr,
  input  logic [AW-1:0] h_adr,
  input  logic [DW-1:0] h_wd,
  input  logic          h_lock,
  output logic          h_gnt,
  output logic          h_rvalid,
  output logic [DW-1:0] h_rd,
  output logic [AW-1:0] m_adr,
  output logic [DW-1:0] m_wd,
  output logic          m_wr,
  input  logic [DW-1:0] m_rd,
  output logic          err
);

  localparam logic [AW-1:0] DEPTH_ADR = AW'(DEPTH);

  typedef enum logic {
    SEL_CPU  = 1'b0,
    SEL_HOST = 1'b1
  } sel_e;

  sel_e last_q, last_d;
  logic lock_q, lock_d;
  logic c_rvalid_q, c_rvalid_d;
  logic h_rvalid_q, h_rvalid_d;
  logic rd_oor_q, rd_oor_d;
  logic err_q, err_d;

  logic          gnt_any;
  logic          sel_wr;
  logic [AW-1:0] sel_adr;
  logic [DW-1:0] sel_wd;
  logic          in_range;

  // Grant: a held lock excludes the CPU only while the host keeps requesting.
  always_comb begin
    c_gnt = 1'b0;
    h_gnt = 1'b0;
    if (rst_n) begin
      if (lock_q && h_req) begin
        h_gnt = 1'b1;
      end else if (c_req && h_req) begin
        if (last_q == SEL_HOST) c_gnt = 1'b1;
        else                    h_gnt = 1'b1;
      end else if (c_req) begin
        c_gnt = 1'b1;
      end else if (h_req) begin
        h_gnt = 1'b1;
      end
    end
  end

  // Memory drive; an idle cycle still presents the CPU address and data.
  always_comb begin
    gnt_any  = c_gnt | h_gnt;
    sel_adr  = h_gnt ? h_adr : c_adr;
    sel_wd   = h_gnt ? h_wd  : c_wd;
    sel_wr   = h_gnt ? h_wr  : c_wr;
    in_range = (sel_adr < DEPTH_ADR);
    m_adr    = rst_n ? sel_adr : '0;
    m_wd     = rst_n ? sel_wd  : '0;
    m_wr     = gnt_any & sel_wr & in_range;
  end

  always_comb begin
    last_d     = last_q;
    lock_d     = lock_q;
    c_rvalid_d = c_gnt & ~c_wr;
    h_rvalid_d = h_gnt & ~h_wr;
    rd_oor_d   = gnt_any & ~sel_wr & ~in_range;
    err_d      = err_q | (gnt_any & ~in_range);
    if (h_gnt)      last_d = SEL_HOST;
    else if (c_gnt) last_d = SEL_CPU;
    if (h_gnt)                 lock_d = h_lock;
    else if (lock_q && !h_req) lock_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_q     <= SEL_HOST;
      lock_q     <= 1'b0;
      c_rvalid_q <= 1'b0;
      h_rvalid_q <= 1'b0;
      rd_oor_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      last_q     <= last_d;
      lock_q     <= lock_d;
      c_rvalid_q <= c_rvalid_d;
      h_rvalid_q <= h_rvalid_d;
      rd_oor_q   <= rd_oor_d;
      err_q      <= err_d;
    end
  end

  // Out-of-range reads return zero instead of whatever the memory drives.
  always_comb begin
    c_rvalid = c_rvalid_q;
    h_rvalid = h_rvalid_q;
    err      = err_q;
    c_rd     = (c_rvalid_q && !rd_oor_q) ? m_rd : '0;
    h_rd     = (h_rvalid_q && !rd_oor_q) ? m_rd : '0;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: stimulus pushes expected read data into per-port
// queues, a monitor pops and compares whenever an rvalid strobe appears.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        c_req, c_wr, h_req, h_wr, h_lock;
  logic [31:0] c_adr, c_wd, h_adr, h_wd;
  logic        c_gnt, c_rvalid, h_gnt, h_rvalid, m_wr, err;
  logic [31:0] c_rd, h_rd, m_adr, m_wd, m_rd;

  logic [31:0] mem [0:1024];
  logic [31:0] exp_c [$];
  logic [31:0] exp_h [$];
  int n_chk  = 0;
  int n_pass = 0;

  dmem_arbiter #(.DW(32), .AW(32), .DEPTH(1025)) dut (
    .clk(clk), .rst_n(rst_n),
    .c_req(c_req), .c_wr(c_wr), .c_adr(c_adr), .c_wd(c_wd),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rd(c_rd),
    .h_req(h_req), .h_wr(h_wr), .h_adr(h_adr), .h_wd(h_wd), .h_lock(h_lock),
    .h_gnt(h_gnt), .h_rvalid(h_rvalid), .h_rd(h_rd),
    .m_adr(m_adr), .m_wd(m_wd), .m_wr(m_wr), .m_rd(m_rd), .err(err)
  );

  always #5 clk = ~clk;

  // Synchronous single-port memory; out-of-range reads return junk the DUT must mask.
  always @(posedge clk) begin
    if (m_wr && m_adr < 32'd1025) mem[m_adr] <= m_wd;
    m_rd <= (m_adr < 32'd1025) ? mem[m_adr] : 32'hBAD0_BAD0;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) chk("gnt_exclusive", 32'(c_gnt & h_gnt), 32'd0);
    if (c_rvalid === 1'b1) begin
      if (exp_c.size() == 0) chk("c_rvalid_unexpected", 32'(c_rvalid), 32'd0);
      else chk("c_rd", c_rd, exp_c.pop_front());
    end
    if (h_rvalid === 1'b1) begin
      if (exp_h.size() == 0) chk("h_rvalid_unexpected", 32'(h_rvalid), 32'd0);
      else chk("h_rd", h_rd, exp_h.pop_front());
    end
  end

  task automatic drive(input logic creq, input logic cwr, input logic [31:0] cadr,
                       input logic [31:0] cwd, input logic hreq, input logic hwr,
                       input logic [31:0] hadr, input logic [31:0] hwd, input logic hlock);
    c_req = creq; c_wr = cwr; c_adr = cadr; c_wd = cwd;
    h_req = hreq; h_wr = hwr; h_adr = hadr; h_wd = hwd; h_lock = hlock;
  endtask

  // One arbitrated cycle with hand-computed grants, write enable and read data.
  task automatic cyc(input logic creq, input logic cwr, input logic [31:0] cadr,
                     input logic [31:0] cwd, input logic hreq, input logic hwr,
                     input logic [31:0] hadr, input logic [31:0] hwd, input logic hlock,
                     input logic eg_c, input logic eg_h, input logic emwr,
                     input logic [31:0] erd);
    drive(creq, cwr, cadr, cwd, hreq, hwr, hadr, hwd, hlock);
    @(negedge clk);
    chk("c_gnt", 32'(c_gnt), 32'(eg_c));
    chk("h_gnt", 32'(h_gnt), 32'(eg_h));
    chk("m_wr", 32'(m_wr), 32'(emwr));
    if (eg_c || eg_h) chk("m_adr", m_adr, eg_h ? hadr : cadr);
    if (eg_c && !cwr) exp_c.push_back(erd);
    if (eg_h && !hwr) exp_h.push_back(erd);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic eerr);
    drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
    @(negedge clk);
    chk("err", 32'(err), 32'(eerr));
    chk("idle_m_wr", 32'(m_wr), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 1025; i++) mem[i] = 32'd0;
    rst_n = 1'b0;
    drive(1'b1, 1'b1, 32'd5, 32'h1234_5678, 1'b1, 1'b1, 32'd6, 32'h9999_9999, 1'b0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_c_gnt", 32'(c_gnt), 32'd0);
    chk("rst_h_gnt", 32'(h_gnt), 32'd0);
    chk("rst_m_wr", 32'(m_wr), 32'd0);
    chk("rst_m_adr", m_adr, 32'd0);
    chk("rst_m_wd", m_wd, 32'd0);
    chk("rst_c_rvalid", 32'(c_rvalid), 32'd0);
    chk("rst_h_rvalid", 32'(h_rvalid), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // CPU write then read back; preload adr 1 (CPU) and adr 2 (host, leaves last=HOST)
    cyc(1,1,32'd5,32'hDEAD_BEEF, 0,0,0,0,0,  1,0,1, 32'd0);
    cyc(1,0,32'd5,32'd0,         0,0,0,0,0,  1,0,0, 32'hDEAD_BEEF);
    cyc(1,1,32'd1,32'h0000_0111, 0,0,0,0,0,  1,0,1, 32'd0);
    cyc(0,0,0,0, 1,1,32'd2,32'h0000_0222,0,  0,1,1, 32'd0);

    // Contention: CPU, HOST, CPU, HOST
    cyc(1,0,32'd1,0, 1,0,32'd2,0,0,  1,0,0, 32'h0000_0111);
    cyc(1,0,32'd1,0, 1,0,32'd2,0,0,  0,1,0, 32'h0000_0222);
    cyc(1,0,32'd1,0, 1,0,32'd2,0,0,  1,0,0, 32'h0000_0111);
    cyc(1,0,32'd1,0, 1,0,32'd2,0,0,  0,1,0, 32'h0000_0222);

    // Host locked read-modify-write of adr 10 while the CPU keeps requesting
    cyc(1,0,32'd5,0, 0,0,0,0,0,  1,0,0, 32'hDEAD_BEEF);
    cyc(1,0,32'd1,0, 1,0,32'd10,0,1,           0,1,0, 32'd0);
    cyc(1,0,32'd1,0, 1,1,32'd10,32'h11,0,      0,1,1, 32'd0);
    cyc(1,0,32'd1,0, 0,0,0,0,0,                1,0,0, 32'h0000_0111);
    cyc(1,0,32'd10,0, 0,0,0,0,0,               1,0,0, 32'h0000_0011);

    // Out of range: write suppressed, read returns 0, err sticky
    idle(1'b0);
    cyc(0,0,0,0, 1,1,32'd1025,32'h55,0,  0,1,0, 32'd0);
    idle(1'b1);
    cyc(0,0,0,0, 1,0,32'd1025,0,0,       0,1,0, 32'd0);
    idle(1'b1);
    idle(1'b1);

    // Reset right after a CPU read grant
    cyc(1,0,32'd5,0, 0,0,0,0,0,  1,0,0, 32'hDEAD_BEEF);
    rst_n = 1'b0;
    drive(1'b1, 1'b0, 32'd1, 32'd0, 1'b1, 1'b0, 32'd2, 32'd0, 1'b0);
    @(negedge clk);
    chk("rst_mid_c_gnt", 32'(c_gnt), 32'd0);
    chk("rst_mid_c_rvalid", 32'(c_rvalid), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("post_rst_c_rvalid", 32'(c_rvalid), 32'd0);
    chk("post_rst_err", 32'(err), 32'd0);
    cyc(1,0,32'd1,0, 1,0,32'd2,0,0,  1,0,0, 32'h0000_0111);

    // Lock released when the host drops its request
    cyc(0,0,0,0, 1,0,32'd2,0,1,      0,1,0, 32'h0000_0222);
    cyc(1,0,32'd1,0, 0,0,0,0,0,      1,0,0, 32'h0000_0111);
    cyc(1,0,32'd5,0, 1,0,32'd2,0,0,  0,1,0, 32'h0000_0222);
    cyc(1,0,32'd5,0, 1,0,32'd2,0,0,  1,0,0, 32'hDEAD_BEEF);

    idle(1'b0);
    idle(1'b0);
    chk("c_queue_drained", 32'(exp_c.size()), 32'd0);
    chk("h_queue_drained", 32'(exp_h.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
